uart_tx_arb: RTL and testbench

- Shares the single UART transmit path (the byte-write port into the UART TX FIFO) between N_REQ requesters, such as the CPU core and a debug/boot loader.
- Round-robin arbitration with message locking: once granted, a requester keeps the UART until it sends a byte flagged last, so multi-byte messages are never interleaved.
- An idle timeout releases a stalled lock.
- Sits between the requesters and the UART wrapper's write interface.

---
 rtl/uart_tx_arb_pkg.sv | 16 +
 rtl/uart_tx_arb_if.sv | 26 ++
 rtl/uart_tx_arb_rr_pick.sv | 27 ++
 rtl/uart_tx_arb.sv | 109 ++++++++++
 tb/tb_uart_tx_arb.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
package uart_tx_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side and UART-side handshake bundle of the transmit arbiter.
interface uart_tx_arb_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    tx_valid;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_ready;
  logic [N_REQ-1:0]        grant;
  logic                    busy;
  logic                    to_evt;

  modport slave (
    input  req_valid, req_last, req_data, tx_ready,
    output req_ready, tx_valid, tx_data, grant, busy, to_evt
  );

  modport master (
    output req_valid, req_last, req_data, tx_ready,
    input  req_ready, tx_valid, tx_data, grant, busy, to_evt
  );
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin finder: first set bit of req at or above ptr, with wrap.
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic             found
);
  logic [PTR_W:0] idx;

  // One extra index bit so the wrap is exact for non-power-of-two N.
  always_comb begin
    onehot = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(N)) idx = idx - (PTR_W+1)'(N);
      if (!found && req[idx[PTR_W-1:0]]) begin
        onehot[idx[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin, message-locking arbiter sharing one UART TX write port; idle timeout frees stalled locks.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 8,
  parameter int IDLE_TO = 1024,
  parameter int CNT_W   = 11
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_arb_if.slave  bus
);
  localparam int PTR_W = clog2(N_REQ);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d, pick;
  logic [PTR_W-1:0]   rr_q, rr_d, owner, owner_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               to_q, to_d;
  logic               found, gv, g_last, xfer;
  logic [DATA_W-1:0]  data_mux;

  rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req    (bus.req_valid),
    .ptr    (rr_q),
    .onehot (pick),
    .found  (found)
  );

  always_comb begin
    owner    = '0;
    data_mux = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        owner    = PTR_W'(i);
        data_mux = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign owner_nxt = (owner == PTR_W'(N_REQ-1)) ? '0 : owner + PTR_W'(1);
  assign gv        = |(grant_q & bus.req_valid);
  assign g_last    = |(grant_q & bus.req_valid & bus.req_last);
  assign xfer      = gv & bus.tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // A last-byte transfer is checked first so it always beats the timeout.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (found) begin
          grant_d = pick;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (xfer && g_last) begin
          state_d = ST_IDLE;
          grant_d = '0;
          rr_d    = owner_nxt;
          cnt_d   = '0;
        end else if (gv) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(IDLE_TO-1)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          rr_d    = owner_nxt;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign bus.tx_valid  = gv;
  assign bus.tx_data   = data_mux;
  assign bus.req_ready = grant_q & {N_REQ{bus.tx_ready}};
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == ST_LOCK);
  assign bus.to_evt    = to_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed and randomized bench for uart_tx_arb (2 requesters, 16-cycle idle timeout).
module tb_uart_tx_arb;
  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  uart_tx_arb_if #(.N_REQ(2), .DATA_W(8)) bus ();

  uart_tx_arb #(.N_REQ(2), .DATA_W(8), .IDLE_TO(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-requester pending bytes {last, data}, the byte log seen at the UART, and the expected order.
  logic [8:0] src0[$], src1[$];
  int         log_cyc[$], log_own[$];
  logic [7:0] log_data[$];
  int         exp_own[$];
  logic [7:0] exp_data[$];
  int         to_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.tx_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_traffic(input int max_cyc, input bit rnd);
    int cyc;
    int own;
    logic [1:0] acc;
    cyc = 0;
    to_seen = 0;
    log_cyc.delete(); log_own.delete(); log_data.delete();
    while ((src0.size() > 0 || src1.size() > 0) && cyc < max_cyc) begin
      if (src0.size() > 0) begin
        bus.req_valid[0]   = !(rnd && bus.grant[0] && ($urandom_range(0, 3) == 0));
        bus.req_data[7:0]  = src0[0][7:0];
        bus.req_last[0]    = src0[0][8];
      end else bus.req_valid[0] = 1'b0;
      if (src1.size() > 0) begin
        bus.req_valid[1]   = !(rnd && bus.grant[1] && ($urandom_range(0, 3) == 0));
        bus.req_data[15:8] = src1[0][7:0];
        bus.req_last[1]    = src1[0][8];
      end else bus.req_valid[1] = 1'b0;
      bus.tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (bus.to_evt) to_seen++;
      if (bus.tx_valid && bus.tx_ready) begin
        acc = bus.req_ready & bus.req_valid;
        own = (acc == 2'b01) ? 0 : (acc == 2'b10) ? 1 : -1;
        log_cyc.push_back(cyc);
        log_own.push_back(own);
        log_data.push_back(bus.tx_data);
        if (own == 0) void'(src0.pop_front());
        if (own == 1) void'(src1.pop_front());
      end
      @(posedge clk);
      #1 cyc++;
    end
    bus.req_valid = '0;
  endtask

  initial begin
    int bad, pulses;
    logic [7:0] t3_data [8];
    int         t3_own  [8];
    t3_data = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA0, 8'hA1, 8'hB0, 8'hB1};
    t3_own  = '{0, 0, 1, 1, 0, 0, 1, 1};

    // 1: reset state
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.tx_ready  = 1'b0;
    @(negedge clk);
    check("rst_grant",    32'(bus.grant),     32'h0);
    check("rst_busy",     32'(bus.busy),      32'h0);
    check("rst_tx_valid", 32'(bus.tx_valid),  32'h0);
    check("rst_req_rdy",  32'(bus.req_ready), 32'h0);
    check("rst_tx_data",  32'(bus.tx_data),   32'h0);
    check("rst_to_evt",   32'(bus.to_evt),    32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 2: single requester, three-byte message
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h0041;
    bus.req_last  = 2'b00;
    bus.tx_ready  = 1'b1;
    @(negedge clk);
    check("t2_idle_grant", 32'(bus.grant),    32'h0);
    check("t2_idle_txv",   32'(bus.tx_valid), 32'h0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      check("t2_grant",   32'(bus.grant),     32'h1);
      check("t2_txv",     32'(bus.tx_valid),  32'h1);
      check("t2_req_rdy", 32'(bus.req_ready), 32'h1);
      check("t2_data",    32'(bus.tx_data),   32'h41 + 32'(b));
      @(posedge clk);
      #1;
      if (b < 2) begin
        bus.req_data = 16'(8'h42 + b);
        bus.req_last = (b == 1) ? 2'b01 : 2'b00;
      end else bus.req_valid = 2'b00;
    end
    @(negedge clk);
    check("t2_end_grant", 32'(bus.grant), 32'h0);
    check("t2_end_busy",  32'(bus.busy),  32'h0);

    // 3: contention from reset, alternating whole messages with one bubble between
    do_reset();
    src0.delete(); src1.delete();
    for (int k = 0; k < 2; k++) begin
      src0.push_back(9'h0A0); src0.push_back(9'h1A1);
      src1.push_back(9'h0B0); src1.push_back(9'h1B1);
    end
    run_traffic(200, 1'b0);
    check("t3_drained", 32'(src0.size() + src1.size()), 32'h0);
    check("t3_count",   32'(log_data.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_data.size(); i++) begin
      check("t3_data",  32'(log_data[i]), 32'(t3_data[i]));
      check("t3_owner", 32'(log_own[i]),  32'(t3_own[i]));
      if (i > 0)
        check("t3_spacing", 32'(log_cyc[i] - log_cyc[i-1]), (i % 2 == 0) ? 32'd2 : 32'd1);
    end

    // 4: long backpressure mid-message must not time out
    do_reset();
    bus.req_valid = 2'b10;
    bus.req_data  = 16'h1000;
    bus.req_last  = 2'b00;
    bus.tx_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_grant", 32'(bus.grant), 32'h2);
    @(posedge clk);
    #1;
    bus.req_data = 16'h1100;
    bus.req_last = 2'b10;
    bus.tx_ready = 1'b0;
    bad = 0; pulses = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus.to_evt) pulses++;
      if (bus.tx_data !== 8'h11 || bus.grant !== 2'b10 || bus.req_ready !== 2'b00) bad++;
    end
    check("t4_no_timeout", 32'(pulses), 32'h0);
    check("t4_held",       32'(bad),    32'h0);
    @(posedge clk);
    #1 bus.tx_ready = 1'b1;
    @(negedge clk);
    check("t4_resume_rdy", 32'(bus.req_ready), 32'h2);
    check("t4_resume_dat", 32'(bus.tx_data),   32'h11);
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    @(negedge clk);
    check("t4_end_grant", 32'(bus.grant), 32'h0);

    // 5: stalled owner released after 16 idle cycles, waiting requester follows
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_data  = 16'h6050;
    bus.req_last  = 2'b10;
    bus.tx_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_grant0", 32'(bus.grant), 32'h1);
    @(posedge clk);
    #1 bus.req_valid = 2'b10;
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (bus.to_evt !== 1'b0 || bus.grant !== 2'b01) bad++;
    end
    check("t5_wait", 32'(bad), 32'h0);
    @(negedge clk);
    check("t5_to_evt", 32'(bus.to_evt), 32'h1);
    check("t5_grant_rel", 32'(bus.grant), 32'h0);
    check("t5_busy_rel",  32'(bus.busy),  32'h0);
    @(negedge clk);
    check("t5_to_once", 32'(bus.to_evt),  32'h0);
    check("t5_grant1",  32'(bus.grant),   32'h2);
    check("t5_data1",   32'(bus.tx_data), 32'h60);
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    @(negedge clk);
    check("t5_end_grant", 32'(bus.grant), 32'h0);

    // 6: asynchronous reset while locked mid-message
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h0070;
    bus.req_last  = 2'b00;
    bus.tx_ready  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 bus.req_data = 16'h0071;
    #1 check("t6_locked", 32'(bus.grant), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("t6_async_grant", 32'(bus.grant),    32'h0);
    check("t6_async_busy",  32'(bus.busy),     32'h0);
    check("t6_async_txv",   32'(bus.tx_valid), 32'h0);
    bus.req_valid = 2'b10;
    bus.req_data  = 16'h8000;
    bus.req_last  = 2'b10;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_post_idle", 32'(bus.grant), 32'h0);
    @(negedge clk);
    check("t6_req1_wins", 32'(bus.grant),   32'h2);
    check("t6_req1_data", 32'(bus.tx_data), 32'h80);
    @(posedge clk);
    #1 bus.req_valid = 2'b00;

    // Random traffic: both requesters always backlogged, so whole messages strictly alternate.
    do_reset();
    src0.delete(); src1.delete(); exp_own.delete(); exp_data.delete();
    for (int m = 0; m < 12; m++) begin
      for (int r = 0; r < 2; r++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          logic [7:0] d;
          d = 8'($urandom);
          if (r == 0) src0.push_back({(b == len - 1), d});
          else        src1.push_back({(b == len - 1), d});
          exp_own.push_back(r);
          exp_data.push_back(d);
        end
      end
    end
    run_traffic(4000, 1'b1);
    check("rnd_drained",  32'(src0.size() + src1.size()), 32'h0);
    check("rnd_count",    32'(log_data.size()), 32'(exp_data.size()));
    check("rnd_no_to",    32'(to_seen), 32'h0);
    for (int i = 0; i < exp_data.size() && i < log_data.size(); i++) begin
      check("rnd_owner", 32'(log_own[i]),  32'(exp_own[i]));
      check("rnd_data",  32'(log_data[i]), 32'(exp_data[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
